// File: rtl/onchip_mem_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : onchip_mem_rr_arbiter_if
//  Brief    : Bundle of the two Avalon-MM master ports and the RAM s1 port.
//  Revision : 1.0 - initial release
// ============================================================================
interface onchip_mem_rr_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] a_address;
  logic              a_read;
  logic              a_write;
  logic [BE_W-1:0]   a_byteenable;
  logic [DATA_W-1:0] a_writedata;
  logic              a_waitrequest;
  logic [DATA_W-1:0] a_readdata;
  logic              a_readdatavalid;

  logic [ADDR_W-1:0] b_address;
  logic              b_read;
  logic              b_write;
  logic [BE_W-1:0]   b_byteenable;
  logic [DATA_W-1:0] b_writedata;
  logic              b_waitrequest;
  logic [DATA_W-1:0] b_readdata;
  logic              b_readdatavalid;

  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  // slave: the arbiter's view (slave to A/B, driving the RAM)
  modport slave (
    input  a_address, a_read, a_write, a_byteenable, a_writedata,
    output a_waitrequest, a_readdata, a_readdatavalid,
    input  b_address, b_read, b_write, b_byteenable, b_writedata,
    output b_waitrequest, b_readdata, b_readdatavalid,
    output mem_address, mem_byteenable, mem_chipselect, mem_write,
    output mem_writedata, mem_clken,
    input  mem_readdata
  );

  // master: the masters' and RAM's view
  modport master (
    output a_address, a_read, a_write, a_byteenable, a_writedata,
    input  a_waitrequest, a_readdata, a_readdatavalid,
    output b_address, b_read, b_write, b_byteenable, b_writedata,
    input  b_waitrequest, b_readdata, b_readdatavalid,
    input  mem_address, mem_byteenable, mem_chipselect, mem_write,
    input  mem_writedata, mem_clken,
    output mem_readdata
  );
endinterface
`default_nettype wire

// File: rtl/onchip_mem_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : onchip_mem_rr_arbiter
//  Brief    : Two-master round-robin arbiter in front of a single-port RAM.
//  Revision : 1.0 - initial release
// ============================================================================
module onchip_mem_rr_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  wire logic               clk,
  input  wire logic               reset,
  onchip_mem_rr_arbiter_if.slave  bus
);
  localparam int         BE_W      = DATA_W / 8;
  localparam logic [0:0] c_OWNER_A = 1'b0;
  localparam logic [0:0] c_OWNER_B = 1'b1;

  logic [0:0]              r_last_grant;
  logic [READ_LATENCY-1:0] r_pipe_valid;
  logic [READ_LATENCY-1:0] r_pipe_owner;
  logic [ADDR_W-1:0]       r_addr_hold;
  logic [BE_W-1:0]         r_be_hold;
  logic [DATA_W-1:0]       r_wdata_hold;

  logic              w_req_a;
  logic              w_req_b;
  logic              w_grant_a;
  logic              w_grant_b;
  logic              w_grant;
  logic [0:0]        w_owner;
  logic              w_sel_write;
  logic              w_issue_read;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [BE_W-1:0]   w_sel_be;
  logic [DATA_W-1:0] w_sel_wdata;

  assign w_req_a = bus.a_read | bus.a_write;
  assign w_req_b = bus.b_read | bus.b_write;

  // On contention the master that did not win last time gets the slot
  assign w_grant_a = !reset && w_req_a && (!w_req_b || (r_last_grant == c_OWNER_B));
  assign w_grant_b = !reset && w_req_b && (!w_req_a || (r_last_grant == c_OWNER_A));
  assign w_grant   = w_grant_a | w_grant_b;
  assign w_owner   = w_grant_b ? c_OWNER_B : c_OWNER_A;

  always_comb begin
    w_sel_write = 1'b0;
    w_sel_addr  = bus.a_address;
    w_sel_be    = bus.a_byteenable;
    w_sel_wdata = bus.a_writedata;
    if (w_grant_a) begin
      w_sel_write = bus.a_write;
    end else if (w_grant_b) begin
      w_sel_write = bus.b_write;
      w_sel_addr  = bus.b_address;
      w_sel_be    = bus.b_byteenable;
      w_sel_wdata = bus.b_writedata;
    end
  end

  // read&write together resolves to a write, so it never enters the read pipe
  assign w_issue_read = w_grant && !w_sel_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= c_OWNER_B;
      r_pipe_valid <= '0;
      r_pipe_owner <= '0;
      r_addr_hold  <= '0;
      r_be_hold    <= '0;
      r_wdata_hold <= '0;
    end else begin
      if (w_grant) begin
        r_last_grant <= w_owner;
        r_addr_hold  <= w_sel_addr;
        r_be_hold    <= w_sel_be;
        r_wdata_hold <= w_sel_wdata;
      end
      r_pipe_valid[0] <= w_issue_read;
      r_pipe_owner[0] <= w_owner;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pipe_valid[i] <= r_pipe_valid[i-1];
        r_pipe_owner[i] <= r_pipe_owner[i-1];
      end
    end
  end

  assign bus.mem_chipselect = w_grant;
  assign bus.mem_write      = w_grant && w_sel_write;
  assign bus.mem_address    = w_grant ? w_sel_addr  : r_addr_hold;
  assign bus.mem_byteenable = w_grant ? w_sel_be    : r_be_hold;
  assign bus.mem_writedata  = w_grant ? w_sel_wdata : r_wdata_hold;
  assign bus.mem_clken      = 1'b1;

  assign bus.a_waitrequest = !w_grant_a;
  assign bus.b_waitrequest = !w_grant_b;

  assign bus.a_readdata = bus.mem_readdata;
  assign bus.b_readdata = bus.mem_readdata;

  assign bus.a_readdatavalid = !reset && r_pipe_valid[READ_LATENCY-1]
                               && (r_pipe_owner[READ_LATENCY-1] == c_OWNER_A);
  assign bus.b_readdatavalid = !reset && r_pipe_valid[READ_LATENCY-1]
                               && (r_pipe_owner[READ_LATENCY-1] == c_OWNER_B);

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(bus.a_read && bus.a_write))
        else $warning("onchip_mem_rr_arbiter: port A read+write together, handled as write");
      assert (!(bus.b_read && bus.b_write))
        else $warning("onchip_mem_rr_arbiter: port B read+write together, handled as write");
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_onchip_mem_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_onchip_mem_rr_arbiter
//  Brief    : Directed bench; one arbiter at READ_LATENCY=1, one at 3.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_onchip_mem_rr_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  onchip_mem_rr_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus1 ();
  onchip_mem_rr_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus3 ();

  onchip_mem_rr_arbiter #(.ADDR_W(10), .DATA_W(32), .READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave));
  onchip_mem_rr_arbiter #(.ADDR_W(10), .DATA_W(32), .READ_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3.slave));

  // RAM models: unwritten words read back as {16'hC0DE, 6'b0, addr}
  function automatic logic [31:0] init_word(input logic [9:0] a);
    return {16'hC0DE, 6'b0, a};
  endfunction

  logic [31:0] ram1 [0:1023];
  bit          wr1  [0:1023];
  logic [31:0] rd1;
  logic [31:0] ram3 [0:1023];
  bit          wr3  [0:1023];
  logic [31:0] p3 [0:2];

  always @(posedge clk) begin
    logic [31:0] cur;
    if (bus1.mem_chipselect) begin
      cur = wr1[bus1.mem_address] ? ram1[bus1.mem_address] : init_word(bus1.mem_address);
      if (bus1.mem_write) begin
        for (int i = 0; i < 4; i++)
          if (bus1.mem_byteenable[i]) cur[i*8 +: 8] = bus1.mem_writedata[i*8 +: 8];
        ram1[bus1.mem_address] <= cur;
        wr1[bus1.mem_address]  <= 1'b1;
      end else begin
        rd1 <= cur;
      end
    end
  end
  assign bus1.mem_readdata = rd1;

  always @(posedge clk) begin
    logic [31:0] cur;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
    if (bus3.mem_chipselect) begin
      cur = wr3[bus3.mem_address] ? ram3[bus3.mem_address] : init_word(bus3.mem_address);
      if (bus3.mem_write) begin
        for (int i = 0; i < 4; i++)
          if (bus3.mem_byteenable[i]) cur[i*8 +: 8] = bus3.mem_writedata[i*8 +: 8];
        ram3[bus3.mem_address] <= cur;
        wr3[bus3.mem_address]  <= 1'b1;
      end else begin
        p3[0] <= cur;
      end
    end
  end
  assign bus3.mem_readdata = p3[2];

  task automatic idle1();
    bus1.a_read = 0; bus1.a_write = 0; bus1.a_address = '0; bus1.a_byteenable = 4'hF; bus1.a_writedata = '0;
    bus1.b_read = 0; bus1.b_write = 0; bus1.b_address = '0; bus1.b_byteenable = 4'hF; bus1.b_writedata = '0;
  endtask

  task automatic idle3();
    bus3.a_read = 0; bus3.a_write = 0; bus3.a_address = '0; bus3.a_byteenable = 4'hF; bus3.a_writedata = '0;
    bus3.b_read = 0; bus3.b_write = 0; bus3.b_address = '0; bus3.b_byteenable = 4'hF; bus3.b_writedata = '0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    bus1.a_read = 1; bus1.b_write = 1;
    @(negedge clk);
    n_cmp++; if (bus1.a_waitrequest !== 1'b1) begin n_err++; $display("FAIL rst_a_wait: got %b want 1", bus1.a_waitrequest); end
    n_cmp++; if (bus1.b_waitrequest !== 1'b1) begin n_err++; $display("FAIL rst_b_wait: got %b want 1", bus1.b_waitrequest); end
    n_cmp++; if (bus1.mem_chipselect !== 1'b0) begin n_err++; $display("FAIL rst_cs: got %b want 0", bus1.mem_chipselect); end
    n_cmp++; if (bus1.mem_write !== 1'b0) begin n_err++; $display("FAIL rst_write: got %b want 0", bus1.mem_write); end
    n_cmp++; if (bus1.a_readdatavalid !== 1'b0 || bus1.b_readdatavalid !== 1'b0) begin
      n_err++; $display("FAIL rst_rdv: got a=%b b=%b want 0 0", bus1.a_readdatavalid, bus1.b_readdatavalid); end
    n_cmp++; if (bus1.mem_clken !== 1'b1) begin n_err++; $display("FAIL clken: got %b want 1", bus1.mem_clken); end
    @(posedge clk); #1;
    reset = 0; idle1();
  endtask

  task automatic test_single_read();
    @(posedge clk); #1;
    bus1.a_read = 1; bus1.a_address = 10'h005;
    @(negedge clk);
    n_cmp++; if (bus1.a_waitrequest !== 1'b0) begin n_err++; $display("FAIL rd_a_wait: got %b want 0", bus1.a_waitrequest); end
    n_cmp++; if (bus1.b_waitrequest !== 1'b1) begin n_err++; $display("FAIL rd_b_wait: got %b want 1", bus1.b_waitrequest); end
    n_cmp++; if (bus1.mem_chipselect !== 1'b1 || bus1.mem_write !== 1'b0) begin
      n_err++; $display("FAIL rd_cmd: got cs=%b wr=%b want 1 0", bus1.mem_chipselect, bus1.mem_write); end
    n_cmp++; if (bus1.mem_address !== 10'h005) begin n_err++; $display("FAIL rd_addr: got %h want 005", bus1.mem_address); end
    n_cmp++; if (bus1.a_readdatavalid !== 1'b0) begin n_err++; $display("FAIL rd_early_rdv: got %b want 0", bus1.a_readdatavalid); end
    @(posedge clk); #1;
    idle1();
    @(negedge clk);
    n_cmp++; if (bus1.a_readdatavalid !== 1'b1) begin n_err++; $display("FAIL rd_a_rdv: got %b want 1", bus1.a_readdatavalid); end
    n_cmp++; if (bus1.a_readdata !== 32'hC0DE0005) begin n_err++; $display("FAIL rd_a_data: got %h want c0de0005", bus1.a_readdata); end
    n_cmp++; if (bus1.b_readdatavalid !== 1'b0) begin n_err++; $display("FAIL rd_b_rdv: got %b want 0", bus1.b_readdatavalid); end
    n_cmp++; if (bus1.mem_chipselect !== 1'b0) begin n_err++; $display("FAIL rd_idle_cs: got %b want 0", bus1.mem_chipselect); end
  endtask

  task automatic test_contention_writes();
    int ai = 0;
    int bi = 0;
    @(posedge clk); #1; reset = 1;
    @(posedge clk); #1; reset = 0;
    for (int k = 0; k < 6; k++) begin
      bus1.a_write = 1; bus1.a_address = 10'h010 + 10'(ai); bus1.a_writedata = 32'hA000_0000 + 32'(ai);
      bus1.b_write = 1; bus1.b_address = 10'h200 + 10'(bi); bus1.b_writedata = 32'hB000_0000 + 32'(bi);
      @(negedge clk);
      n_cmp++; if (bus1.a_waitrequest !== 1'(k % 2)) begin
        n_err++; $display("FAIL wr_a_wait[%0d]: got %b want %0d", k, bus1.a_waitrequest, k % 2); end
      n_cmp++; if (bus1.b_waitrequest !== 1'((k + 1) % 2)) begin
        n_err++; $display("FAIL wr_b_wait[%0d]: got %b want %0d", k, bus1.b_waitrequest, (k + 1) % 2); end
      n_cmp++; if (bus1.mem_chipselect !== 1'b1 || bus1.mem_write !== 1'b1) begin
        n_err++; $display("FAIL wr_cmd[%0d]: got cs=%b wr=%b want 1 1", k, bus1.mem_chipselect, bus1.mem_write); end
      if (k % 2 == 0) ai++; else bi++;
      @(posedge clk); #1;
    end
    idle1();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (ram1[10'h010 + 10'(i)] !== 32'hA000_0000 + 32'(i)) begin
        n_err++; $display("FAIL wr_ram_a[%0d]: got %h want %h", i, ram1[10'h010 + 10'(i)], 32'hA000_0000 + 32'(i)); end
      n_cmp++; if (ram1[10'h200 + 10'(i)] !== 32'hB000_0000 + 32'(i)) begin
        n_err++; $display("FAIL wr_ram_b[%0d]: got %h want %h", i, ram1[10'h200 + 10'(i)], 32'hB000_0000 + 32'(i)); end
    end
  endtask

  task automatic test_byteenable();
    bus1.a_write = 1; bus1.a_address = 10'h3FF; bus1.a_writedata = 32'hDEADBEEF; bus1.a_byteenable = 4'b0011;
    @(negedge clk);
    n_cmp++; if (bus1.a_waitrequest !== 1'b0 || bus1.mem_byteenable !== 4'b0011) begin
      n_err++; $display("FAIL be_cmd: got wait=%b be=%b want 0 0011", bus1.a_waitrequest, bus1.mem_byteenable); end
    @(posedge clk); #1;
    idle1();
    bus1.b_read = 1; bus1.b_address = 10'h3FF;
    @(negedge clk);
    n_cmp++; if (bus1.b_waitrequest !== 1'b0) begin n_err++; $display("FAIL be_b_wait: got %b want 0", bus1.b_waitrequest); end
    @(posedge clk); #1;
    idle1();
    @(negedge clk);
    n_cmp++; if (bus1.b_readdatavalid !== 1'b1) begin n_err++; $display("FAIL be_b_rdv: got %b want 1", bus1.b_readdatavalid); end
    n_cmp++; if (bus1.b_readdata !== 32'hC0DEBEEF) begin n_err++; $display("FAIL be_data: got %h want c0debeef", bus1.b_readdata); end
    n_cmp++; if (bus1.a_readdatavalid !== 1'b0) begin n_err++; $display("FAIL be_a_rdv: got %b want 0", bus1.a_readdatavalid); end
    @(posedge clk); #1;
  endtask

  task automatic test_read_write_both();
    bus1.a_read = 1; bus1.a_write = 1; bus1.a_address = 10'h020; bus1.a_writedata = 32'h55AA55AA;
    @(negedge clk);
    n_cmp++; if (bus1.mem_write !== 1'b1 || bus1.mem_chipselect !== 1'b1 || bus1.a_waitrequest !== 1'b0) begin
      n_err++; $display("FAIL rw_cmd: got wr=%b cs=%b wait=%b want 1 1 0", bus1.mem_write, bus1.mem_chipselect, bus1.a_waitrequest); end
    @(posedge clk); #1;
    idle1();
    @(negedge clk);
    n_cmp++; if (bus1.a_readdatavalid !== 1'b0 || bus1.b_readdatavalid !== 1'b0) begin
      n_err++; $display("FAIL rw_rdv: got a=%b b=%b want 0 0", bus1.a_readdatavalid, bus1.b_readdatavalid); end
    n_cmp++; if (ram1[10'h020] !== 32'h55AA55AA) begin n_err++; $display("FAIL rw_ram: got %h want 55aa55aa", ram1[10'h020]); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    bus1.a_read = 1; bus1.a_address = 10'h005;
    @(negedge clk);
    n_cmp++; if (bus1.a_waitrequest !== 1'b0) begin n_err++; $display("FAIL rm_a_wait: got %b want 0", bus1.a_waitrequest); end
    @(posedge clk); #1;
    idle1(); reset = 1;
    @(negedge clk);
    n_cmp++; if (bus1.a_readdatavalid !== 1'b0) begin n_err++; $display("FAIL rm_rdv_in_reset: got %b want 0", bus1.a_readdatavalid); end
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    n_cmp++; if (bus1.a_readdatavalid !== 1'b0) begin n_err++; $display("FAIL rm_rdv_after: got %b want 0", bus1.a_readdatavalid); end
    @(posedge clk); #1;
    bus1.a_read = 1; bus1.a_address = 10'h005;
    bus1.b_read = 1; bus1.b_address = 10'h006;
    @(negedge clk);
    n_cmp++; if (bus1.a_waitrequest !== 1'b0 || bus1.b_waitrequest !== 1'b1) begin
      n_err++; $display("FAIL rm_first_grant: got a_wait=%b b_wait=%b want 0 1", bus1.a_waitrequest, bus1.b_waitrequest); end
    @(posedge clk); #1;
    idle1();
    @(negedge clk);
    n_cmp++; if (bus1.a_readdatavalid !== 1'b1 || bus1.a_readdata !== 32'hC0DE0005) begin
      n_err++; $display("FAIL rm_a_data: got v=%b d=%h want 1 c0de0005", bus1.a_readdatavalid, bus1.a_readdata); end
  endtask

  // Both masters read continuously for 4 cycles on the latency-3 arbiter
  task automatic test_back_to_back();
    int ai = 0;
    int bi = 0;
    @(posedge clk); #1;
    for (int c = 0; c < 8; c++) begin
      int   g;
      logic ev_a, ev_b;
      logic [31:0] ed;
      if (c < 4) begin
        bus3.a_read = 1; bus3.a_address = 10'h040 + 10'(ai);
        bus3.b_read = 1; bus3.b_address = 10'h080 + 10'(bi);
      end else begin
        idle3();
      end
      @(negedge clk);
      if (c < 4) begin
        n_cmp++; if (bus3.a_waitrequest !== 1'(c % 2) || bus3.b_waitrequest !== 1'((c + 1) % 2)) begin
          n_err++; $display("FAIL b2b_wait[%0d]: got a=%b b=%b want %0d %0d", c, bus3.a_waitrequest, bus3.b_waitrequest, c % 2, (c + 1) % 2); end
        if (c % 2 == 0) ai++; else bi++;
      end
      g    = c - 3;
      ev_a = (g >= 0) && (g < 4) && (g % 2 == 0);
      ev_b = (g >= 0) && (g < 4) && (g % 2 == 1);
      ed   = ev_a ? init_word(10'h040 + 10'(g / 2)) : init_word(10'h080 + 10'((g - 1) / 2));
      n_cmp++; if (bus3.a_readdatavalid !== ev_a || bus3.b_readdatavalid !== ev_b) begin
        n_err++; $display("FAIL b2b_rdv[%0d]: got a=%b b=%b want %b %b", c, bus3.a_readdatavalid, bus3.b_readdatavalid, ev_a, ev_b); end
      if (ev_a) begin
        n_cmp++; if (bus3.a_readdata !== ed) begin n_err++; $display("FAIL b2b_a_data[%0d]: got %h want %h", c, bus3.a_readdata, ed); end
      end
      if (ev_b) begin
        n_cmp++; if (bus3.b_readdata !== ed) begin n_err++; $display("FAIL b2b_b_data[%0d]: got %h want %h", c, bus3.b_readdata, ed); end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1;
    idle1();
    idle3();
    repeat (2) @(posedge clk);
    test_reset();
    test_single_read();
    test_contention_writes();
    test_byteenable();
    test_read_write_both();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
